// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // A digit at or above this value is corrected before the next shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Number of decimal digits needed to represent 2^width-1.
  function automatic int unsigned digits(input int unsigned width);
    longint unsigned max_val;
    int unsigned     n;
    max_val = (64'd1 << width) - 64'd1;
    n = 0;
    while (max_val != 0) begin
      max_val = max_val / 10;
      n++;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Operand/result handshake bundle for bin2bcd_seq.
// out_sign only exists when BIN2BCD_SIGNED_EN is defined.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = bin2bcd_pkg::digits(WIDTH)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
`ifdef BIN2BCD_SIGNED_EN
  logic                  out_sign;
`endif

  // Producer of operands / consumer of results.
  modport master (
    output in_valid,
    output in_bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
`ifdef BIN2BCD_SIGNED_EN
    input  out_sign,
`endif
    input  out_bcd
  );

  // The converter itself.
  modport slave (
    input  in_valid,
    input  in_bin,
    input  out_ready,
    output in_ready,
    output out_valid,
`ifdef BIN2BCD_SIGNED_EN
    output out_sign,
`endif
    output out_bcd
  );

endinterface

// File: rtl/bin2bcd_dabble_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bin2bcd_dabble_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Pre-shift correction.
  always_comb begin
    adjusted = digit;
    if (digit >= BCD_ADJ_THRESH) adjusted = digit + BCD_ADJ_ADD;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Accepts an operand in IDLE, iterates WIDTH times in SHIFT, presents the
// result in DONE until out_ready. out_bcd keeps the last result afterwards.
// Optional BIN2BCD_SIGNED_EN: in_bin is two's complement, magnitude is
// converted and the sign is reported on out_sign.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = digits(WIDTH)
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   operand;
  logic               accept;
  logic               last_iter;
  // The top digit never exceeds 4 before a shift, so its carry-out is always 0.
  logic               unused_adj_msb;

  assign accept         = (state_q == IDLE) && bus.in_valid;
  assign last_iter      = (state_q == SHIFT) && (cnt_q == '0);
  assign bcd_shift      = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  assign unused_adj_msb = bcd_adj[BCD_W-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bin2bcd_dabble_digit u_digit (
      .digit    (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q;

  // Negative operands are converted by magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  always_comb begin
    operand = bus.in_bin;
    if (bus.in_bin[WIDTH-1]) operand = WIDTH'(~bus.in_bin) + WIDTH'(1);
  end

  // Sign is captured with the operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (accept) begin
      sign_q <= bus.in_bin[WIDTH-1];
    end
  end

  assign bus.out_sign = sign_q;
`else
  // Unsigned operands convert as-is.
  always_comb begin
    operand = bus.in_bin;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SHIFT exits on count 0, never on counter wrap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working shift registers, iteration counter and published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      bin_q <= operand;
      bcd_q <= '0;
      cnt_q <= CNT_W'(WIDTH - 1);
    end else if (state_q == SHIFT) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_shift;
      if (last_iter) begin
        result_q <= bcd_shift;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bcd   = result_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: WIDTH=8 instance driven from a vector
// table plus corner sequences and checked every cycle against a scoreboard;
// WIDTH=4 instance swept exhaustively.
module tb_bin2bcd_seq;

  localparam int W8 = 8;
  localparam int D8 = 3;
  localparam int W4 = 4;
  localparam int D4 = 2;

  typedef enum logic [1:0] {M_IDLE, M_SHIFT, M_DONE} mstate_t;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        sign;
  } vec_t;

  typedef struct {
    logic [31:0] bcd;
    logic        sign;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(W8), .DIGITS(D8)) bus8 ();
  bin2bcd_seq_if #(.WIDTH(W4), .DIGITS(D4)) bus4 ();

  bin2bcd_seq #(.WIDTH(W8), .DIGITS(D8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  bin2bcd_seq #(.WIDTH(W4), .DIGITS(D4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or no expectation (t=%0t)", name, $time);
  endtask

  // Reference conversion by repeated division, independent of double-dabble.
  function automatic void ref_conv(input logic [31:0] raw, input int w,
                                   output logic s, output logic [31:0] bcd);
    logic [31:0] mask;
    logic [31:0] mag;
    mask = (32'd1 << w) - 32'd1;
    mag  = raw & mask;
    s    = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (mag[w-1]) begin
      s   = 1'b1;
      mag = (~mag + 32'd1) & mask;
    end
`endif
    bcd = '0;
    for (int i = 0; i < 8; i++) begin
      bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
  endfunction

  // Protocol model of the WIDTH=8 converter plus result scoreboard.
  mstate_t     m = M_IDLE;
  int          mcnt = 0;
  exp_t        sb[$];
  exp_t        drv_exp;
  logic [31:0] last_bcd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m        <= M_IDLE;
      mcnt     <= 0;
      last_bcd <= '0;
      sb.delete();
    end else begin
      case (m)
        M_IDLE: if (bus8.in_valid) begin
          m    <= M_SHIFT;
          mcnt <= W8 - 1;
          sb.push_back(drv_exp);
        end
        M_SHIFT: if (mcnt == 0) m <= M_DONE; else mcnt <= mcnt - 1;
        M_DONE: if (bus8.out_ready) begin
          m <= M_IDLE;
          if (sb.size() > 0) begin
            last_bcd <= sb[0].bcd;
            void'(sb.pop_front());
          end
        end
        default: m <= M_IDLE;
      endcase
    end
  end

  // Every cycle: handshake flags follow the model; result held/stable as expected.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("in_ready", 32'(bus8.in_ready), 32'(m == M_IDLE));
      check("out_valid", 32'(bus8.out_valid), 32'(m == M_DONE));
      if (m == M_DONE) begin
        if (sb.size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          check("out_bcd", 32'(bus8.out_bcd), sb[0].bcd);
`ifdef BIN2BCD_SIGNED_EN
          check("out_sign", 32'(bus8.out_sign), 32'(sb[0].sign));
`endif
        end
      end else begin
        check("out_bcd_hold", 32'(bus8.out_bcd), last_bcd);
      end
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] eb, input logic es);
    int t;
    t = 0;
    @(negedge clk);
    while (m != M_IDLE && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (m != M_IDLE) fail_now("send_wait_idle");
    drv_exp.bcd   = eb;
    drv_exp.sign  = es;
    bus8.in_bin   = b[W8-1:0];
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(m == M_IDLE && sb.size() == 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(m == M_IDLE && sb.size() == 0)) fail_now("drain");
  endtask

  vec_t        vecs[8];
  logic        rs;
  logic [31:0] rb;

  initial begin
    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_bin    = '0;
    bus8.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_bin    = '0;
    bus4.out_ready = 1'b1;
    drv_exp.bcd    = '0;
    drv_exp.sign   = 1'b0;

`ifdef BIN2BCD_SIGNED_EN
    vecs[0] = '{32'h80, 32'h128, 1'b1};
    vecs[1] = '{32'hFF, 32'h001, 1'b1};
    vecs[2] = '{32'h7F, 32'h127, 1'b0};
    vecs[3] = '{32'h00, 32'h000, 1'b0};
    vecs[4] = '{32'h09, 32'h009, 1'b0};
    vecs[5] = '{32'h9C, 32'h100, 1'b1};
    vecs[6] = '{32'h01, 32'h001, 1'b0};
    vecs[7] = '{32'hD6, 32'h042, 1'b1};
`else
    vecs[0] = '{32'd255, 32'h255, 1'b0};
    vecs[1] = '{32'd0,   32'h000, 1'b0};
    vecs[2] = '{32'd9,   32'h009, 1'b0};
    vecs[3] = '{32'd100, 32'h100, 1'b0};
    vecs[4] = '{32'd42,  32'h042, 1'b0};
    vecs[5] = '{32'd128, 32'h128, 1'b0};
    vecs[6] = '{32'd99,  32'h099, 1'b0};
    vecs[7] = '{32'd1,   32'h001, 1'b0};
`endif

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready8", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
    check("rst_out_bcd8", 32'(bus8.out_bcd), 32'd0);
    check("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
    check("rst_out_bcd4", 32'(bus4.out_bcd), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
    check("rst_out_sign8", 32'(bus8.out_sign), 32'd0);
`endif
    rst = 1'b0;

    // Vector table, out_ready held high.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].bin, vecs[i].bcd, vecs[i].sign);
      drain();
    end

    // Back-to-back 0 then 9.
    send(32'd0, 32'h000, 1'b0);
    send(32'd9, 32'h009, 1'b0);
    drain();

    // Stall on 100 with ignored in_valid pulses during SHIFT and DONE.
    bus8.out_ready = 1'b0;
    send(32'd100, 32'h100, 1'b0);
    bus8.in_bin   = 8'd77;
    bus8.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus8.in_valid = 1'b0;
    for (int t = 0; t < 20 && m != M_DONE; t++) @(negedge clk);
    if (m != M_DONE) fail_now("stall_reach_done");
    for (int k = 0; k < 5; k++) begin
      bus8.in_valid = k[0];
      @(negedge clk);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    drain();

    // Reset at iteration 3 of 200 aborts; then 42 converts normally.
    ref_conv(32'd200, W8, rs, rb);
    send(32'd200, rb, rs);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    check("abort_out_bcd", 32'(bus8.out_bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);
    send(32'd42, 32'h042, 1'b0);
    drain();

    // Random operands with random result back-pressure.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = 32'($urandom_range(0, 255));
      ref_conv(v, W8, rs, rb);
      bus8.out_ready = 1'b0;
      send(v, rb, rs);
      repeat ($urandom_range(0, 12)) @(negedge clk);
      bus8.out_ready = 1'b1;
      drain();
    end

    // WIDTH=4 exhaustive sweep with latency check.
    for (int v = 0; v < 16; v++) begin
      int lat;
      int t;
      ref_conv(32'(v), W4, rs, rb);
      t = 0;
      @(negedge clk);
      while (!bus4.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus4.in_ready) fail_now("w4_wait_ready");
      bus4.in_bin   = 4'(v);
      bus4.in_valid = 1'b1;
      @(posedge clk);
      #1 bus4.in_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (bus4.out_valid) begin
          lat = i;
          break;
        end
      end
      check("w4_latency", 32'(lat), 32'(W4));
      check("w4_bcd", 32'(bus4.out_bcd), rb);
`ifdef BIN2BCD_SIGNED_EN
      check("w4_sign", 32'(bus4.out_sign), 32'(rs));
`endif
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
